// File: rtl/jsv_nios2_debug_jtag_pkg.sv
// Shared types and constants for the Nios II virtual-JTAG debug master.
package jsv_nios2_debug_jtag_pkg;

  localparam int unsigned DR_WIDTH_DEF = 38;
  localparam int unsigned IR_WIDTH_DEF = 2;
  localparam int unsigned TCK_DIV_DEF  = 4;
  localparam int unsigned BIT_CNT_W    = 6;
  localparam int unsigned TCK_CNT_W    = 8;

  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SDR,
    ST_UDR,
    ST_RSP
  } jtag_state_e;

  // TCK runs only while a virtual-state sequence is in flight.
  function automatic logic tck_active(input jtag_state_e s);
    return (s == ST_UIR) || (s == ST_CDR) || (s == ST_SDR) || (s == ST_UDR);
  endfunction

endpackage

// File: rtl/jsv_nios2_debug_jtag_tck_gen.sv
// Divided TCK generator: low half first, plus edge strobes for the cycle whose clk edge moves TCK.
module jsv_nios2_debug_jtag_tck_gen
  import jsv_nios2_debug_jtag_pkg::*;
#(
  parameter int unsigned TCK_DIV = TCK_DIV_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic tck_rise_c,
  output logic tck_fall_c
);

  localparam logic [TCK_CNT_W-1:0] CNT_LAST = TCK_CNT_W'(TCK_DIV - 1);

  logic [TCK_CNT_W-1:0] cnt_q;
  logic                 wrap_c;

  assign wrap_c     = en && (cnt_q == CNT_LAST);
  assign tck_rise_c = wrap_c && !tck;
  assign tck_fall_c = wrap_c && tck;

  // Disabling the divider parks TCK low and restarts the half-period count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tck   <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0;
      tck   <= 1'b0;
    end else if (wrap_c) begin
      cnt_q <= '0;
      tck   <= ~tck;
    end else begin
      cnt_q <= cnt_q + TCK_CNT_W'(1);
    end
  end

endmodule

// File: rtl/jsv_nios2_debug_jtag_master.sv
// Host-side initiator: one command -> UIR/CDR/SDR/UDR on the virtual JTAG link -> captured DR response.
module jsv_nios2_debug_jtag_master
  import jsv_nios2_debug_jtag_pkg::*;
#(
  parameter int unsigned TCK_DIV  = TCK_DIV_DEF,
  parameter int unsigned DR_WIDTH = DR_WIDTH_DEF,
  parameter int unsigned IR_WIDTH = IR_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_rti,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr
);

  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DR_WIDTH - 1);

  jtag_state_e          state_q, state_d;
  logic [DR_WIDTH-1:0]  tx_q;
  logic [DR_WIDTH-1:0]  rx_q;
  logic [BIT_CNT_W-1:0] bit_q;
  logic                 tck_en_c;
  logic                 tck_rise_c;
  logic                 tck_fall_c;
  logic                 cmd_fire_c;
  logic                 rsp_fire_c;

  assign cmd_fire_c = cmd_valid && cmd_ready;
  assign rsp_fire_c = rsp_valid && rsp_ready;
  assign tck_en_c   = tck_active(state_q);

  jsv_nios2_debug_jtag_tck_gen #(
    .TCK_DIV(TCK_DIV)
  ) u_tck_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (tck_en_c),
    .tck       (vji_tck),
    .tck_rise_c(tck_rise_c),
    .tck_fall_c(tck_fall_c)
  );

  // Virtual-state sequencing; every TCK-domain transition lands on a TCK falling edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_fire_c) state_d = ST_UIR;
      ST_UIR:  if (tck_fall_c) state_d = ST_CDR;
      ST_CDR:  if (tck_fall_c) state_d = ST_SDR;
      ST_SDR:  if (tck_fall_c && (bit_q == BIT_LAST)) state_d = ST_UDR;
      ST_UDR:  if (tck_fall_c) state_d = ST_RSP;
      ST_RSP:  if (rsp_fire_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Registered handshakes, state indicators and the DR shift/capture datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_dr    <= '0;
      rsp_ir    <= '0;
      vji_tdi   <= 1'b0;
      vji_ir_in <= '0;
      vji_rti   <= 1'b1;
      vji_uir   <= 1'b0;
      vji_cdr   <= 1'b0;
      vji_sdr   <= 1'b0;
      vji_udr   <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_q     <= '0;
    end else begin
      cmd_ready <= (state_d == ST_IDLE);
      rsp_valid <= (state_d == ST_RSP);
      vji_rti   <= (state_d == ST_IDLE);
      vji_uir   <= (state_d == ST_UIR);
      vji_cdr   <= (state_d == ST_CDR);
      vji_sdr   <= (state_d == ST_SDR);
      vji_udr   <= (state_d == ST_UDR);

      if (cmd_fire_c) begin
        tx_q      <= cmd_dr;
        vji_ir_in <= cmd_ir;
      end

      if ((state_q == ST_UIR) && tck_rise_c) rsp_ir <= vji_ir_out;
      if ((state_q == ST_SDR) && tck_rise_c) rx_q <= {vji_tdo, rx_q[DR_WIDTH-1:1]};

      // TDI presents bit 0 on SDR entry and advances one bit per falling edge.
      if (state_d != ST_SDR) begin
        vji_tdi <= 1'b0;
      end else if (state_q != ST_SDR) begin
        vji_tdi <= tx_q[0];
        bit_q   <= '0;
      end else if (tck_fall_c) begin
        vji_tdi <= tx_q[1];
        tx_q    <= {1'b0, tx_q[DR_WIDTH-1:1]};
        bit_q   <= bit_q + BIT_CNT_W'(1);
      end

      if ((state_q == ST_UDR) && tck_fall_c) rsp_dr <= rx_q;
    end
  end

endmodule

// File: tb/tb_jsv_nios2_debug_jtag_master.sv
// Directed bench for the virtual-JTAG debug master with a loopback slave model on TDO.
module tb_jsv_nios2_debug_jtag_master;
  import jsv_nios2_debug_jtag_pkg::*;

  localparam int unsigned DRW = 38;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [1:0]     cmd_ir = 2'b00;
  logic [DRW-1:0] cmd_dr = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [DRW-1:0] rsp_dr;
  logic [1:0]     rsp_ir;
  logic           vji_tck, vji_tdi, vji_tdo;
  logic [1:0]     vji_ir_in;
  logic [1:0]     vji_ir_out = 2'b01;
  logic           vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr;

  jsv_nios2_debug_jtag_master dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ir    (cmd_ir),
    .cmd_dr    (cmd_dr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dr    (rsp_dr),
    .rsp_ir    (rsp_ir),
    .vji_tck   (vji_tck),
    .vji_tdi   (vji_tdi),
    .vji_tdo   (vji_tdo),
    .vji_ir_in (vji_ir_in),
    .vji_ir_out(vji_ir_out),
    .vji_rti   (vji_rti),
    .vji_uir   (vji_uir),
    .vji_cdr   (vji_cdr),
    .vji_sdr   (vji_sdr),
    .vji_udr   (vji_udr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: k counts TCK rises in SDR; TDO presents word bit k, TDI is logged per rise.
  logic [6:0]     k = '0;
  logic [DRW-1:0] tdo_word = '0;
  logic [DRW-1:0] tdi_cap = '0;
  always @(posedge vji_tck or posedge vji_uir) begin
    if (vji_uir) k <= '0;
    else if (vji_sdr) begin
      if (k < 7'd38) tdi_cap[k[5:0]] <= vji_tdi;
      k <= k + 7'd1;
    end
  end
  assign vji_tdo = (k < 7'd38) ? tdo_word[k[5:0]] : 1'b0;

  // Strobe occupancy monitors.
  int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_ovl = 0, n_irbad = 0;
  logic [1:0] exp_ir = 2'b00;
  always @(negedge clk) begin
    if (vji_uir) n_uir++;
    if (vji_cdr) n_cdr++;
    if (vji_sdr) n_sdr++;
    if (vji_udr) n_udr++;
    if ($countones({vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr}) > 1) n_ovl++;
    if ((vji_uir || vji_cdr || vji_sdr || vji_udr) && (vji_ir_in !== exp_ir)) n_irbad++;
  end

  int errors = 0;
  int checks = 0;
  int unsigned hs_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] ir, input logic [DRW-1:0] dr);
    int n;
    n = 0;
    @(negedge clk);
    cmd_ir = ir; cmd_dr = dr; cmd_valid = 1'b1; exp_ir = ir;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    hs_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  // Returns the cycle (handshake = 0) where rsp_valid first reads high; 0 on timeout.
  task automatic wait_rsp(input int pulse_at, output int lat);
    lat = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (pulse_at > 0) begin
        if (int'(cyc - hs_cyc) + 1 == pulse_at) begin
          cmd_valid = 1'b1; cmd_ir = 2'b11;
        end else cmd_valid = 1'b0;
      end
      if (rsp_valid) begin
        lat = int'(cyc - hs_cyc) + 1;
        break;
      end
    end
    if (pulse_at > 0) cmd_valid = 1'b0;
  endtask

  initial begin
    int lat, s_uir, s_cdr, s_sdr, s_udr, hold_bad;
    bit found;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset_ctrl", 64'({cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_rti,
                           vji_uir, vji_cdr, vji_sdr, vji_udr}), 64'(9'b1_0001_0000));
    chk("reset_rsp", 64'({rsp_dr, rsp_ir, vji_ir_in}), 64'(0));
    reset_n = 1'b1;

    // T1: BREAK with loopback word; pulse cmd_valid mid-SDR.
    tdo_word = 38'h15_DEAD_BEEF;
    s_uir = n_uir; s_cdr = n_cdr; s_sdr = n_sdr; s_udr = n_udr;
    issue(IR_BREAK, 38'h2A_5555_AAAA);
    wait_rsp(100, lat);
    chk("t1_latency", 64'(lat), 64'(329));
    chk("t1_rsp_dr", 64'(rsp_dr), 64'(38'h15_DEAD_BEEF));
    chk("t1_rsp_ir", 64'(rsp_ir), 64'(2'b01));
    chk("t1_tdi_serial", 64'(tdi_cap), 64'(38'h2A_5555_AAAA));
    chk("t1_uir_len", 64'(n_uir - s_uir), 64'(8));
    chk("t1_cdr_len", 64'(n_cdr - s_cdr), 64'(8));
    chk("t1_sdr_len", 64'(n_sdr - s_sdr), 64'(304));
    chk("t1_udr_len", 64'(n_udr - s_udr), 64'(8));
    chk("t1_ir_in_held", 64'(n_irbad), 64'(0));

    // Response held while rsp_ready low; a queued command must not be taken.
    hold_bad = 0;
    cmd_valid = 1'b1; cmd_ir = IR_TRACEMEM; cmd_dr = 38'h01_2345_6789;
    tdo_word = 38'h3F_FFFF_0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_dr !== 38'h15_DEAD_BEEF ||
          cmd_ready !== 1'b0 || vji_tck !== 1'b0) hold_bad++;
    end
    chk("rsp_hold", 64'(hold_bad), 64'(0));

    // Back-to-back: command only accepted the cycle after the response handshake.
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_ir = IR_TRACEMEM;
    chk("b2b_gap", 64'({cmd_ready, rsp_valid, vji_uir, vji_rti}), 64'(4'b1001));
    @(posedge clk); #1;
    hs_cyc = cyc;
    cmd_valid = 1'b0;
    chk("b2b_accept", 64'({vji_uir, vji_ir_in, cmd_ready}), 64'(4'b1010));

    // T2: reset mid-SDR at bit 17.
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (vji_sdr && k == 7'd17) begin
        found = 1'b1;
        break;
      end
    end
    chk("t2_reach_bit17", 64'(found), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("t2_reset_ctrl", 64'({cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_rti,
                              vji_uir, vji_cdr, vji_sdr, vji_udr}), 64'(9'b1_0001_0000));
    chk("t2_reset_rsp", 64'({rsp_dr, rsp_ir, vji_ir_in}), 64'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // T3: full transaction after reset.
    tdo_word = 38'h0A_AAAA_5555;
    s_sdr = n_sdr;
    issue(IR_TRACECTRL, 38'h2B_CDEF_0123);
    wait_rsp(0, lat);
    chk("t3_latency", 64'(lat), 64'(329));
    chk("t3_rsp_dr", 64'(rsp_dr), 64'(38'h0A_AAAA_5555));
    chk("t3_tdi_serial", 64'(tdi_cap), 64'(38'h2B_CDEF_0123));
    chk("t3_sdr_len", 64'(n_sdr - s_sdr), 64'(304));
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("t3_idle_ir_hold", 64'({cmd_ready, rsp_valid, vji_ir_in}), 64'(4'b1011));
    chk("no_overlap", 64'(n_ovl), 64'(0));
    chk("ir_in_stable", 64'(n_irbad), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jsv_nios2_debug_jtag_master.md
# jsv_nios2_debug_jtag_master

Single-clock initiator for the 2-bit-IR virtual-JTAG debug interface of the Nios II debug slave; drives the host-side end of the link that the slave's TCK-domain logic responds to. Accepts one command (IR value plus 38-bit DR word), generates the UIR/CDR/SDR/UDR sequence with a divided TCK, shifts the DR out LSB-first on TDI, captures TDO, and returns the captured word. Used for in-fabric debug bring-up and as the bench driver for the debug slave.

## Interface
- TCK_DIV, 4: TCK half-period in clk cycles; legal range 1..255.
- DR_WIDTH, 38: data register length.
- IR_WIDTH, 2: instruction register length.

- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle, command accepted when valid&ready.
- cmd_ir  in  IR_WIDTH  instruction to load.
- cmd_dr  in  DR_WIDTH  word to shift in.
- rsp_valid  out  1  captured word available.
- rsp_ready  in  1  consumer accepts response.
- rsp_dr  out  DR_WIDTH  word shifted out of slave.
- rsp_ir  out  IR_WIDTH  vji_ir_out sampled in UIR.
- vji_tck  out  1  generated test clock.
- vji_tdi  out  1  serial data to slave.
- vji_tdo  in  1  serial data from slave.
- vji_ir_in  out  IR_WIDTH  current instruction.
- vji_ir_out  in  IR_WIDTH  slave status.
- vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr  out  1 each  virtual-state indicators.

## Operation
- States: IDLE, UIR, CDR, SDR, UDR, RSP.
- Reset values: state IDLE, cmd_ready 1, rsp_valid 0, rsp_dr 0, rsp_ir 0, vji_tck 0, vji_tdi 0, vji_ir_in 0, vji_rti 1, other vji_* strobes 0.
- IDLE: vji_rti=1, tck held 0; on handshake latch cmd_ir/cmd_dr, drive vji_ir_in=cmd_ir, go UIR.
- UIR, CDR, UDR: each one TCK period; the matching vji_* indicator high for the whole period; rsp_ir sampled from vji_ir_out on UIR's TCK rising edge.
- SDR: exactly DR_WIDTH TCK periods, vji_sdr high. vji_tdi = latched DR bit i (bit 0 first). On each TCK rising edge: rsp shift register <= {vji_tdo, rsp[DR_WIDTH-1:1]}.
- RSP: rsp_valid=1 with rsp_dr stable until rsp_ready; then IDLE. No command accepted in the handshake cycle.
- vji_ir_in holds its value after the transaction until the next command.
- cmd_valid while busy: ignored, no state effect.

## Timing
- TCK period = 2*TCK_DIV clk cycles: low half first, then high half; free-running only outside IDLE/RSP, 0 otherwise.
- Every state boundary and every TDI update coincides with a TCK falling edge (clk cycle where tck goes 1->0, or state entry).
- Handshake at cycle 0 -> UIR entered cycle 1 -> rsp_valid first high at cycle 1 + (DR_WIDTH+3)*2*TCK_DIV (329 at defaults).
- TDO sampled in the clk cycle vji_tck rises.
- TCK_DIV=1: tck toggles every clk; sequence otherwise identical.
- Reset mid-transaction: async return to reset values within the assertion; response discarded; vji_tck forced 0 immediately.

## Structure
- Package jsv_nios2_debug_jtag_pkg: state enum, default DR/IR widths, IR opcode constants (00 OCIMEM, 01 TRACEMEM, 10 BREAK, 11 TRACECTRL).
- Sub-module jsv_nios2_debug_jtag_tck_gen: divider counter producing vji_tck plus one-clk tck_rise/tck_fall strobes, enabled by the FSM.
- Top: FSM, 6-bit bit counter, DR shift/capture registers.

## Test plan
- Reset with rsp_ready=0 -> cmd_ready=1, vji_rti=1, vji_tck=0, all strobes 0.
- Command ir=2'b10, dr=38'h2A_5555_AAAA with loopback tdo model holding 38'h15_DEAD_BEEF -> vji_tdi serial equals dr LSB-first; rsp_dr=38'h15_DEAD_BEEF at cycle 329.
- Observe strobe sequence -> uir, cdr each 8 clk, sdr 304 clk, udr 8 clk, no overlap, ir_in=2'b10 throughout.
- rsp_ready low 20 cycles -> rsp_valid and rsp_dr held stable, cmd_ready stays 0, tck stays 0.
- cmd_valid pulsed during SDR -> ignored; back-to-back commands -> second accepted no earlier than cycle after rsp handshake.
- reset_n dropped mid-SDR (bit 17) -> all outputs at reset values same cycle; next command runs full 38 bits correctly.
